bus_sequencer: RTL and testbench

Transaction controller for `common_bus`, the 16-bit shared bus with 4096-word main memory. It accepts single-word memory read/write requests on a valid/ready handshake and generates the `select`, `data_in`, `LD`, `INR`, `CLR`, `read`, `write` and `enable` sequence. That sequence moves the address through the address register and address bus, then moves the data to or from memory. It sits between the control unit and the `common_bus` instance and is the only driver of the bus control inputs.

---
 rtl/bus_sequencer.sv | 148 ++++++++++++++
 tb/tb_bus_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_sequencer.sv
// Transaction controller for common_bus. It turns single-word read/write requests into
// the select/data_in/LD/read/write/enable sequence that the shared bus expects.
module bus_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic [15:0]       txn_count,
    output logic [2:0]        bus_select,
    output logic [DATA_W-1:0] bus_data_in,
    output logic [5:0]        bus_LD,
    output logic [4:0]        bus_INR,
    output logic [4:0]        bus_CLR,
    output logic              bus_read,
    output logic              bus_write,
    output logic              bus_enable,
    input  logic [DATA_W-1:0] bus_data_out
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_ADDR     = 4'd1;
    localparam logic [3:0] S_LDAR     = 4'd2;
    localparam logic [3:0] S_ASETTLE  = 4'd3;
    localparam logic [3:0] S_WSTROBE  = 4'd4;
    localparam logic [3:0] S_RSTROBE  = 4'd5;
    localparam logic [3:0] S_RSELECT  = 4'd6;
    localparam logic [3:0] S_RCAPTURE = 4'd7;
    localparam logic [3:0] S_DONE     = 4'd8;

    localparam logic [2:0] SEL_DATA_IN = 3'b000;
    localparam logic [2:0] SEL_MEM_DR  = 3'b111;

    logic [3:0]        r_state;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [15:0]       r_txn_count;

    logic [3:0]        w_next_state;
    logic              w_accept;
    logic [DATA_W-1:0] w_addr_ext;

    assign w_addr_ext = {{(DATA_W-ADDR_W){1'b0}}, r_addr};
    assign w_accept   = (r_state == S_IDLE) && req_valid;

    always_comb begin
        w_next_state = S_IDLE;
        case (r_state)
            S_IDLE:     w_next_state = w_accept ? S_ADDR : S_IDLE;
            S_ADDR:     w_next_state = S_LDAR;
            S_LDAR:     w_next_state = S_ASETTLE;
            S_ASETTLE:  w_next_state = r_write ? S_WSTROBE : S_RSTROBE;
            S_WSTROBE:  w_next_state = S_DONE;
            S_RSTROBE:  w_next_state = S_RSELECT;
            S_RSELECT:  w_next_state = S_RCAPTURE;
            S_RCAPTURE: w_next_state = S_DONE;
            S_DONE:     w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_txn_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (r_state == S_RCAPTURE)
                r_rdata <= bus_data_out;
            if (r_state == S_DONE)
                r_txn_count <= r_txn_count + 16'd1;
        end
    end

    // Moore decode: every bus control comes from r_state plus the latched request.
    always_comb begin
        req_ready   = 1'b0;
        busy        = 1'b1;
        rsp_valid   = 1'b0;
        bus_enable  = 1'b1;
        bus_select  = SEL_DATA_IN;
        bus_data_in = '0;
        bus_LD      = '0;
        bus_read    = 1'b0;
        bus_write   = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready  = 1'b1;
                busy       = 1'b0;
                bus_enable = 1'b0;
            end
            S_ADDR: begin
                bus_data_in = w_addr_ext;
            end
            S_LDAR: begin
                bus_data_in = w_addr_ext;
                bus_LD[0]   = 1'b1;
            end
            S_ASETTLE: begin
                // Bus register captures wdata on the same edge the address bus updates.
                bus_data_in = r_write ? r_wdata : w_addr_ext;
            end
            S_WSTROBE: begin
                bus_data_in = r_wdata;
                bus_write   = 1'b1;
            end
            S_RSTROBE: begin
                bus_data_in = w_addr_ext;
                bus_read    = 1'b1;
            end
            S_RSELECT, S_RCAPTURE: begin
                bus_select = SEL_MEM_DR;
            end
            S_DONE: begin
                rsp_valid = 1'b1;
            end
            default: begin
                busy       = 1'b0;
                bus_enable = 1'b0;
            end
        endcase
    end

    assign bus_INR   = '0;
    assign bus_CLR   = '0;
    assign rsp_rdata = r_rdata;
    assign txn_count = r_txn_count;

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer with a small behavioural common_bus model
// (address register, address bus, bus register, memory data register, memory).
module tb_bus_sequencer;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;
    logic [15:0]       txn_count;
    logic [2:0]        bus_select;
    logic [DATA_W-1:0] bus_data_in;
    logic [5:0]        bus_LD;
    logic [4:0]        bus_INR;
    logic [4:0]        bus_CLR;
    logic              bus_read;
    logic              bus_write;
    logic              bus_enable;
    logic [DATA_W-1:0] bus_data_out;

    bus_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy), .txn_count(txn_count),
        .bus_select(bus_select), .bus_data_in(bus_data_in), .bus_LD(bus_LD),
        .bus_INR(bus_INR), .bus_CLR(bus_CLR), .bus_read(bus_read), .bus_write(bus_write),
        .bus_enable(bus_enable), .bus_data_out(bus_data_out)
    );

    always #5 clock = ~clock;

    // common_bus model
    logic [ADDR_W-1:0] m_ar, m_abus;
    logic [DATA_W-1:0] m_bus, m_dr;
    logic [DATA_W-1:0] mem [4096];

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        m_ar = '0; m_abus = '0; m_bus = '0; m_dr = '0;
    end

    always @(posedge clock) begin
        if (bus_enable) begin
            if (bus_LD[0]) m_ar <= bus_data_in[ADDR_W-1:0];
            m_abus <= m_ar;
            m_bus  <= (bus_select == 3'b111) ? m_dr : bus_data_in;
            if (bus_write) mem[m_abus] <= m_bus;
            if (bus_read)  m_dr <= mem[m_abus];
        end
    end
    assign bus_data_out = m_bus;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        int          rsp_cyc;
        logic [15:0] exp_cnt;
    } txn_t;

    txn_t tbl[7];

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
    endtask

    // Issue one transaction and check every cycle up to and including the IDLE cycle after DONE.
    task automatic run_txn(input txn_t t);
        logic [15:0] a16;
        a16 = {4'h0, t.addr};
        wait_ready();
        req_valid = 1'b1; req_write = t.wr; req_addr = t.addr; req_wdata = t.wdata;
        @(negedge clock);
        req_valid = 1'b0; req_addr = ~t.addr; req_wdata = ~t.wdata; req_write = ~t.wr;
        for (int c = 1; c <= t.rsp_cyc; c++) begin
            chk($sformatf("busy_c%0d", c), 32'(busy), 32'd1);
            chk($sformatf("ready_c%0d", c), 32'(req_ready), 32'd0);
            chk($sformatf("enable_c%0d", c), 32'(bus_enable), 32'd1);
            chk($sformatf("rsp_c%0d", c), 32'(rsp_valid), 32'(c == t.rsp_cyc));
            chk($sformatf("ld_c%0d", c), 32'(bus_LD), 32'(c == 2));
            chk($sformatf("inrclr_c%0d", c), {22'd0, bus_INR, bus_CLR}, 32'd0);
            chk($sformatf("read_c%0d", c), 32'(bus_read), 32'(!t.wr && c == 4));
            chk($sformatf("write_c%0d", c), 32'(bus_write), 32'(t.wr && c == 4));
            chk($sformatf("sel_c%0d", c), 32'(bus_select),
                (!t.wr && (c == 5 || c == 6)) ? 32'd7 : 32'd0);
            if (c <= 2)
                chk($sformatf("din_c%0d", c), 32'(bus_data_in), 32'(a16));
            else if (c == 3)
                chk("din_c3", 32'(bus_data_in), t.wr ? 32'(t.wdata) : 32'(a16));
            else if (t.wr && c == 4)
                chk("din_c4", 32'(bus_data_in), 32'(t.wdata));
            if (c < t.rsp_cyc) @(negedge clock);
        end
        if (t.wr) chk("mem_after_write", 32'(mem[t.addr]), 32'(t.wdata));
        else      chk("rsp_rdata", 32'(rsp_rdata), 32'(t.exp_rdata));
        @(negedge clock);
        chk("idle_rsp", 32'(rsp_valid), 32'd0);
        chk("idle_ready", 32'(req_ready), 32'd1);
        chk("idle_enable", 32'(bus_enable), 32'd0);
        chk("txn_count", 32'(txn_count), 32'(t.exp_cnt));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int seen;
        logic [15:0] cnt_before;
        txn_t t;

        tbl[0] = '{1'b1, 12'hFFE, 16'h6789, 16'h0000, 5, 16'd1};
        tbl[1] = '{1'b1, 12'hFFD, 16'h1234, 16'h0000, 5, 16'd2};
        tbl[2] = '{1'b0, 12'hFFE, 16'h0000, 16'h6789, 7, 16'd3};
        tbl[3] = '{1'b0, 12'hFFD, 16'h0000, 16'h1234, 7, 16'd4};
        tbl[4] = '{1'b1, 12'h000, 16'hFFFF, 16'h0000, 5, 16'd5};
        tbl[5] = '{1'b0, 12'h000, 16'h0000, 16'hFFFF, 7, 16'd6};
        tbl[6] = '{1'b0, 12'h001, 16'h0000, 16'h0000, 7, 16'd7};

        // Reset with a request pending
        reset_n = 1'b0; req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h555; req_wdata = 16'hAAAA;
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_cnt", 32'(txn_count), 32'd0);
        chk("rst_sel", 32'(bus_select), 32'd0);
        chk("rst_din", 32'(bus_data_in), 32'd0);
        chk("rst_ld_inr_clr", {16'd0, bus_LD, bus_INR, bus_CLR}, 32'd0);
        chk("rst_rd_wr_en", {29'd0, bus_read, bus_write, bus_enable}, 32'd0);
        req_valid = 1'b0;
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 7; i++) run_txn(tbl[i]);

        // Requests presented while busy are ignored until IDLE; latest fields win
        wait_ready();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'hFFE; req_wdata = 16'h0000;
        @(negedge clock);
        req_write = 1'b1; req_addr = 12'hABC; req_wdata = 16'h5555;
        for (int c = 1; c <= 7; c++) begin
            chk($sformatf("hold_ready_c%0d", c), 32'(req_ready), 32'd0);
            if (c == 3) chk("hold_din_c3", 32'(bus_data_in), 32'h0FFE);
            if (c == 5) begin req_addr = 12'h0AA; req_wdata = 16'hBEEF; end
            if (c == 7) begin
                chk("hold_rsp", 32'(rsp_valid), 32'd1);
                chk("hold_rdata", 32'(rsp_rdata), 32'h6789);
            end
            @(negedge clock);
        end
        chk("hold_idle_ready", 32'(req_ready), 32'd1);
        @(negedge clock);
        req_valid = 1'b0;
        chk("hold_accept_busy", 32'(busy), 32'd1);
        chk("hold_accept_din", 32'(bus_data_in), 32'h00AA);
        n = 1;
        while (!rsp_valid && n < 20) begin @(negedge clock); n++; end
        chk("hold_w_rsp_cycle", 32'(n), 32'd5);
        chk("hold_mem_0AA", 32'(mem[12'h0AA]), 32'hBEEF);
        chk("hold_mem_ABC", 32'(mem[12'hABC]), 32'h0000);
        @(negedge clock);
        chk("hold_cnt", 32'(txn_count), 32'd9);

        // Reset mid-write: reset lands before the write strobe cycle
        wait_ready();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h123; req_wdata = 16'hDEAD;
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (rsp_valid || bus_write) seen++;
            @(negedge clock);
        end
        chk("mid_rst_no_rsp_or_write", 32'(seen), 32'd0);
        chk("mid_rst_mem", 32'(mem[12'h123]), 32'd0);
        chk("mid_rst_cnt", 32'(txn_count), 32'd0);
        chk("mid_rst_rdata", 32'(rsp_rdata), 32'd0);

        // Counter wrap
        force dut.r_txn_count = 16'hFFFF;
        @(negedge clock);
        release dut.r_txn_count;
        @(negedge clock);
        cnt_before = txn_count;
        chk("wrap_preload", 32'(cnt_before), 32'hFFFF);
        t = '{1'b1, 12'h200, 16'h0F0F, 16'h0000, 5, 16'h0000};
        run_txn(t);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
